// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit multi-cycle CPU
// driving datapath strobes and handshaking with one shared variable-latency memory port.
module multicycle_sequencer #(
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         opcode,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCSrc,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegDst,
    output logic               ALUSrc,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic [1:0]         ALUOp,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4;

    typedef enum logic [2:0] {C_NONE, C_R, C_I, C_LW, C_SW, C_BEQ} opClass_e;

    function automatic opClass_e decodeClass(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010: decodeClass = C_R;
            4'b1001, 4'b1010, 4'b1011: decodeClass = C_I;
            4'b1100: decodeClass = C_LW;
            4'b1101: decodeClass = C_SW;
            4'b1111: decodeClass = C_BEQ;
            default: decodeClass = C_NONE;
        endcase
    endfunction

    logic [2:0] state, nextState;
    opClass_e   opClass;
    logic       illegal, memClass;

    assign illegal  = decodeClass(opcode) == C_NONE;
    assign memClass = opClass == C_LW || opClass == C_SW;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            opClass <= C_NONE;
        end else begin
            state   <= nextState;
            opClass <= state == DECODE ? decodeClass(opcode) : opClass;
        end
    end

    always_comb begin
        nextState = FETCH;
        case (state)
            FETCH:   nextState = MemReady ? DECODE : FETCH;
            DECODE:  nextState = illegal ? FETCH : EXEC;
            EXEC:    nextState = (opClass == C_R || opClass == C_I) ? WB : memClass ? MEM : FETCH;
            MEM:     nextState = !memClass ? FETCH : !MemReady ? MEM : opClass == C_LW ? WB : FETCH;
            default: nextState = FETCH;
        endcase
    end

    // Reset masks every output combinationally so an aborted instruction emits nothing.
    always_comb begin
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegDst    = 1'b0;
        ALUSrc    = 1'b0;
        MemToReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUOp     = 2'b00;
        IllegalOp = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                DECODE: IllegalOp = illegal;
                EXEC: begin
                    RegDst  = opClass == C_R;
                    ALUSrc  = opClass == C_I || memClass;
                    PCSrc   = opClass == C_BEQ;
                    PCWrite = opClass == C_BEQ && Zero;
                    ALUOp   = opClass == C_R ? 2'b10 : opClass == C_I ? 2'b11 :
                              opClass == C_BEQ ? 2'b01 : 2'b00;
                end
                MEM: begin
                    IorD     = 1'b1;
                    ALUSrc   = 1'b1;
                    MemRead  = opClass == C_LW;
                    MemWrite = opClass == C_SW;
                end
                WB: begin
                    RegWrite = 1'b1;
                    RegDst   = opClass == C_R;
                    MemToReg = opClass == C_LW;
                end
                default: ;
            endcase
        end
    end

    assign State = reset ? '0 : STATE_W'(state);
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the 16-bit CPU. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the shared datapath's control strobes one phase at a time. It handshakes with a single variable-latency memory port that serves both instruction fetch and data access. It sits between the instruction register and the datapath, in place of single-cycle combinational control.

## Interface
Parameters:
- STATE_W, 3, width of the state output.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  IR[15:12]; valid from the DECODE state onward.
- Zero  in  1  ALU zero flag; sampled in EXEC.
- MemReady  in  1  memory completion for the current request (same-cycle allowed).
- PCWrite  out  1  PC load enable.
- PCSrc  out  1  0 = PC+2, 1 = branch target.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- IRWrite  out  1  instruction register load.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- RegDst  out  1  1 = rd, 0 = rt.
- ALUSrc  out  1  1 = immediate.
- MemToReg  out  1  1 = memory data to register file.
- RegWrite  out  1  register file write enable.
- ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded, 11 immediate-op.
- IllegalOp  out  1  one-cycle pulse on an undefined opcode.
- State  out  STATE_W  current state, for debug.

Clock and reset: one clock (`clk`); `reset` is synchronous and active-high.

## Operation
State encoding:
- FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.
- Codes 5–7 are unreachable; if entered, the next state is FETCH.

Opcode classes, latched into an internal register on the DECODE cycle:
- R: 0000, 0001, 0010.
- I: 1001, 1010, 1011.
- LW: 1100. SW: 1101. BEQ: 1111.
- Anything else is illegal.

Outputs are a Moore decode of state plus the latched class. Zero and MemReady are added Mealy-style only where stated. Every strobe not listed for a state is 0.

FETCH:
- Drives IorD=0, MemRead=1.
- While MemReady=0, holds the state and keeps the request stable.
- When MemReady=1, asserts IRWrite=1, PCWrite=1, PCSrc=0 in that same cycle, then goes to DECODE.

DECODE:
- All strobes 0.
- Latches opcode.
- If the opcode is illegal: pulses IllegalOp and goes to FETCH. Otherwise goes to EXEC.

EXEC:
- R: ALUOp=10, RegDst=1, ALUSrc=0; next WB. SLL/SRA (0010) use ALUSrc=0, never X.
- I: ALUOp=11, ALUSrc=1; next WB.
- LW/SW: ALUOp=00, ALUSrc=1; next MEM.
- BEQ: ALUOp=01, ALUSrc=0, PCSrc=1, PCWrite=Zero; next FETCH.

MEM:
- Drives IorD=1, ALUSrc=1, ALUOp=00.
- LW drives MemRead=1; SW drives MemWrite=1.
- Holds until MemReady=1.
- Then SW goes to FETCH and LW goes to WB.

WB:
- Drives RegWrite=1 for exactly one cycle.
- R: RegDst=1. I/LW: RegDst=0.
- MemToReg=1 for LW only.
- Next FETCH.

Reset:
- While reset=1, every output is 0, including MemRead and MemWrite.
- State is forced to FETCH and the latched class is cleared.
- Reset asserted mid-instruction (including during a MEM wait) aborts it. No RegWrite, PCWrite or MemWrite is issued from the aborted instruction.
- The first request after reset deasserts is a FETCH read.

## Timing
Latency with zero wait states (MemReady high on the first request cycle):
- BEQ: 3 cycles.
- R, I, SW: 4 cycles.
- LW: 5 cycles.
- Illegal opcode: 2 cycles.

Each memory wait cycle adds one cycle in FETCH or MEM.

Memory request rules:
- MemRead/MemWrite and IorD stay constant from the first request cycle through the MemReady cycle.
- They drop in the following cycle.
- MemReady outside FETCH/MEM is ignored.

Strobe rules:
- IRWrite and PCWrite in FETCH are high only in the cycle MemReady=1.
- Back-to-back instructions: WB or a branch EXEC is followed directly by FETCH, with no idle cycle.
- Never active in the same cycle: RegWrite with MemWrite; IRWrite with RegWrite.

## Test plan
- **Reset mid-LW:** reset pulsed during a LW MEM wait (MemReady=0) → next cycle State=0, all strobes 0. The next cycle drives MemRead=1, IorD=0. RegWrite never asserts for that LW.
- **ADD (0001), zero wait:** → State 0,1,2,4,0. RegWrite=1 only in cycle 4 with RegDst=1, MemToReg=0. Cycle 3 shows ALUOp=10.
- **LW (1100), 3 fetch and 2 data wait cycles:** → 10 cycles total. MemRead stays high through each wait. In WB, RegWrite=1, MemToReg=1, RegDst=0.
- **SW (1101):** → MEM drives MemWrite=1, IorD=1. No WB state follows and RegWrite stays 0.
- **BEQ (1111):**
  - Zero=1 → EXEC has PCWrite=1, PCSrc=1; next state FETCH.
  - Zero=0 → PCWrite=0.
- **Illegal opcode (0111):** → IllegalOp=1 in DECODE for one cycle, returns to FETCH. No RegWrite, MemWrite or extra PCWrite is issued.
